// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - TMDS control tokens, TERC4 code table and popcount helper
package tmds_pkg;

  // Control-period tokens, indexed by {C1,C0}
  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  // TERC4 data-island codes; first listed entry is nibble F, last is nibble 0
  localparam logic [15:0][9:0] TERC4_TABLE = {
    10'b1011000011, 10'b0101100011, 10'b1001110001, 10'b1010001110,
    10'b1011000110, 10'b0110011100, 10'b0100111001, 10'b1011001100,
    10'b0100111100, 10'b0110001110, 10'b0100011110, 10'b0101110001,
    10'b1011100010, 10'b1011100100, 10'b1001100011, 10'b1010011100
  };

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  function automatic logic [9:0] terc4_code(input logic [3:0] nib);
    return TERC4_TABLE[nib];
  endfunction

endpackage

// File: rtl/tmds_encoder.sv
// rtl/tmds_encoder.sv - two-stage TMDS 8b/10b channel encoder; TMDS_TERC4_EN adds TERC4 data-island output
module tmds_encoder
  import tmds_pkg::*;
#(
  parameter logic [9:0] RST_TOKEN = 10'b1101010100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] vid_data,
  input  logic       vid_de,
  input  logic [1:0] ctrl,
  input  logic [3:0] aux_data,
  input  logic       aux_valid,
  output logic [9:0] tmds_out
);

  logic [8:0]        qm_d, qm_q;
  logic              de_q;
  logic [1:0]        ctrl_q;
  logic [3:0]        n1q, n0q;
  logic signed [4:0] diff;
  logic signed [4:0] cnt_d, cnt_q;
  logic [9:0]        word_d, word_q;

`ifdef TMDS_TERC4_EN
  logic [3:0] aux_data_q;
  logic       aux_valid_q;
`else
  logic unused_aux;
  assign unused_aux = ^{aux_data, aux_valid};
`endif

  // Stage 1: transition-minimising XOR/XNOR chain over the input byte
  always_comb begin
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] qm;
    n1       = popcount8(vid_data);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !vid_data[0]);
    qm       = '0;
    qm[0]    = vid_data[0];
    for (int i = 1; i < 8; i++) begin
      qm[i] = use_xnor ? ~(qm[i-1] ^ vid_data[i]) : (qm[i-1] ^ vid_data[i]);
    end
    qm[8] = ~use_xnor;
    qm_d  = qm;
  end

  // Stage 1 register: chained byte plus the side-band it travels with
  always_ff @(posedge clk) begin
    if (rst) begin
      qm_q   <= '0;
      de_q   <= 1'b0;
      ctrl_q <= 2'b00;
`ifdef TMDS_TERC4_EN
      aux_data_q  <= '0;
      aux_valid_q <= 1'b0;
`endif
    end else begin
      qm_q   <= qm_d;
      de_q   <= vid_de;
      ctrl_q <= ctrl;
`ifdef TMDS_TERC4_EN
      aux_data_q  <= aux_data;
      aux_valid_q <= aux_valid;
`endif
    end
  end

  assign n1q  = popcount8(qm_q[7:0]);
  assign n0q  = 4'd8 - n1q;
  assign diff = $signed({1'b0, n1q}) - $signed({1'b0, n0q});

  // Stage 2: DC-balancing inversion choice during video, fixed symbols during blanking
  always_comb begin
    word_d = RST_TOKEN;
    cnt_d  = 5'sd0;
    if (de_q) begin
      if ((cnt_q == 5'sd0) || (diff == 5'sd0)) begin
        word_d = qm_q[8] ? {2'b01, qm_q[7:0]} : {2'b10, ~qm_q[7:0]};
        cnt_d  = qm_q[8] ? (cnt_q + diff) : (cnt_q - diff);
      end else if (((cnt_q > 5'sd0) && (diff > 5'sd0)) ||
                   ((cnt_q < 5'sd0) && (diff < 5'sd0))) begin
        word_d = {1'b1, qm_q[8], ~qm_q[7:0]};
        cnt_d  = cnt_q + (qm_q[8] ? 5'sd2 : 5'sd0) - diff;
      end else begin
        word_d = {1'b0, qm_q[8], qm_q[7:0]};
        cnt_d  = cnt_q + diff - (qm_q[8] ? 5'sd0 : 5'sd2);
      end
    end else begin
      cnt_d = 5'sd0;
      case (ctrl_q)
        2'b00:   word_d = CTRL_TOKEN_00;
        2'b01:   word_d = CTRL_TOKEN_01;
        2'b10:   word_d = CTRL_TOKEN_10;
        default: word_d = CTRL_TOKEN_11;
      endcase
`ifdef TMDS_TERC4_EN
      if (aux_valid_q) begin
        word_d = terc4_code(aux_data_q);
      end
`endif
    end
  end

  // Stage 2 register: output symbol and running disparity
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= RST_TOKEN;
      cnt_q  <= 5'sd0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign tmds_out = word_q;

endmodule

// File: tb/tb_tmds_encoder.sv
// tb/tb_tmds_encoder.sv - scoreboard bench for tmds_encoder against a behavioural 8b/10b model
module tb_tmds_encoder;

  localparam logic [9:0] RST_TOKEN = 10'b1101010100;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] vid_data;
  logic       vid_de;
  logic [1:0] ctrl;
  logic [3:0] aux_data;
  logic       aux_valid;
  logic [9:0] tmds_out;

  always #5 clk = ~clk;

  tmds_encoder #(.RST_TOKEN(RST_TOKEN)) dut (
    .clk(clk), .rst(rst), .vid_data(vid_data), .vid_de(vid_de), .ctrl(ctrl),
    .aux_data(aux_data), .aux_valid(aux_valid), .tmds_out(tmds_out)
  );

  typedef struct {
    int         due;
    logic [9:0] word;
    int         cnt;
    logic       chk_data;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   m_cnt = 0;

`ifdef TMDS_TERC4_EN
  logic [9:0] terc4_tab [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };
`endif

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [9:0] token(input logic [1:0] c);
    case (c)
      2'b00:   return 10'b1101010100;
      2'b01:   return 10'b0010101011;
      2'b10:   return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  // Reference encoder: q_m bit i is the parity of d[0..i], flipped on odd i in XNOR mode
  task automatic model_video(input logic [7:0] d, output logic [9:0] w);
    int         n1, n1q, df;
    logic       inv, q8;
    logic [7:0] qm, mask;
    n1  = $countones(d);
    inv = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    for (int i = 0; i < 8; i++) begin
      mask  = 8'((1 << (i + 1)) - 1);
      qm[i] = (($countones(d & mask) % 2) == 1) ^ (inv && (i % 2 == 1));
    end
    q8  = !inv;
    n1q = $countones(qm);
    df  = 2 * n1q - 8;
    if (m_cnt == 0 || df == 0) begin
      w     = q8 ? {2'b01, qm} : {2'b10, ~qm};
      m_cnt = m_cnt + (q8 ? df : -df);
    end else if ((m_cnt > 0 && df > 0) || (m_cnt < 0 && df < 0)) begin
      w     = {1'b1, q8, ~qm};
      m_cnt = m_cnt + (q8 ? 2 : 0) - df;
    end else begin
      w     = {1'b0, q8, qm};
      m_cnt = m_cnt + df - (q8 ? 0 : 2);
    end
  endtask

  function automatic logic [7:0] tmds_decode(input logic [9:0] w);
    logic [7:0] b, d;
    b    = w[9] ? ~w[7:0] : w[7:0];
    d[0] = b[0];
    for (int i = 1; i < 8; i++) d[i] = w[8] ? (b[i] ^ b[i-1]) : ~(b[i] ^ b[i-1]);
    return d;
  endfunction

  // Present one input cycle and queue the symbol expected two cycles later
  task automatic drive(input logic r, input logic de, input logic [7:0] d, input logic [1:0] c,
                       input logic [3:0] ad, input logic av,
                       input logic use_x, input logic [9:0] xw, input int xc);
    exp_t e, p;
    e.due = cyc + 2;
    e.chk_data = 1'b0;
    e.data = d;
    if (r) begin
      if (sb.size() > 0 && sb[$].due == cyc + 1) begin
        p = sb.pop_back();
        p.word = RST_TOKEN; p.cnt = 0; p.chk_data = 1'b0;
        sb.push_back(p);
      end
      m_cnt  = 0;
      e.word = RST_TOKEN;
    end else if (de) begin
      model_video(d, e.word);
      e.chk_data = 1'b1;
    end else begin
      m_cnt  = 0;
      e.word = token(c);
`ifdef TMDS_TERC4_EN
      if (av) e.word = terc4_tab[ad];
`endif
    end
    e.cnt = m_cnt;
    if (use_x) begin
      e.word = xw;
      e.cnt  = xc;
    end
    rst = r; vid_de = de; vid_data = d; ctrl = c; aux_data = ad; aux_valid = av;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop each expected symbol on its due cycle and compare
  exp_t mon_e;
  int   dut_cnt;
  always @(negedge clk) begin
    dut_cnt = dut.cnt_q;
    n_cmp++;
    if (dut_cnt > 8 || dut_cnt < -8) begin
      n_fail++;
      $display("FAIL cnt_bound cyc=%0d got=%0d required=-8..8", cyc, dut_cnt);
    end
    if (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      n_cmp++;
      if (mon_e.due != cyc) begin
        n_fail++;
        $display("FAIL sb_due cyc=%0d got=%0d required=%0d", cyc, cyc, mon_e.due);
      end
      n_cmp++;
      if (tmds_out !== mon_e.word) begin
        n_fail++;
        $display("FAIL tmds_out cyc=%0d got=%b required=%b", cyc, tmds_out, mon_e.word);
      end
      n_cmp++;
      if (dut_cnt != mon_e.cnt) begin
        n_fail++;
        $display("FAIL cnt cyc=%0d got=%0d required=%0d", cyc, dut_cnt, mon_e.cnt);
      end
      if (mon_e.chk_data) begin
        n_cmp++;
        if (tmds_decode(tmds_out) !== mon_e.data) begin
          n_fail++;
          $display("FAIL decode cyc=%0d got=%h required=%h", cyc, tmds_decode(tmds_out), mon_e.data);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int burst;
    logic cur_de;
    logic [9:0] dc_words [4];
    int         dc_cnts [4];
    dc_words[0] = 10'b0100000000; dc_words[1] = 10'b1111111111;
    dc_words[2] = 10'b0100000000; dc_words[3] = 10'b1111111111;
    dc_cnts[0] = -8; dc_cnts[1] = 2; dc_cnts[2] = -6; dc_cnts[3] = 4;
    rst = 1'b1; vid_de = 1'b0; vid_data = '0; ctrl = 2'b00; aux_data = '0; aux_valid = 1'b0;

    for (int i = 0; i < 3; i++) drive(1, 0, 8'h00, 2'b00, 4'h0, 0, 1, 10'b1101010100, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 8'h00, 2'b00, 4'h0, 0, 1, 10'b1101010100, 0);

    drive(0, 0, 8'h00, 2'b00, 4'h0, 0, 1, 10'b1101010100, 0);
    drive(0, 0, 8'h00, 2'b01, 4'h0, 0, 1, 10'b0010101011, 0);
    drive(0, 0, 8'h00, 2'b10, 4'h0, 0, 1, 10'b0101010100, 0);
    drive(0, 0, 8'h00, 2'b11, 4'h0, 0, 1, 10'b1010101011, 0);

    for (int i = 0; i < 4; i++) drive(0, 1, 8'h00, 2'b00, 4'h0, 0, 1, dc_words[i], dc_cnts[i]);
    drive(0, 0, 8'h00, 2'b00, 4'h0, 0, 1, 10'b1101010100, 0);
    drive(0, 1, 8'hFF, 2'b00, 4'h0, 0, 1, 10'b1000000000, -8);
    drive(0, 0, 8'h00, 2'b11, 4'h0, 0, 1, 10'b1010101011, 0);

    for (int i = 0; i < 16; i++) begin
      if (i == 8) drive(0, 1, 8'($urandom), 2'b00, 4'hA, 1, 0, '0, 0);
      drive(0, 0, 8'h00, 2'(i), 4'(i), 1, 0, '0, 0);
    end

    for (int i = 0; i < 6; i++) drive(0, 1, 8'($urandom), 2'b00, 4'h0, 0, 0, '0, 0);
    drive(1, 0, 8'h00, 2'b00, 4'h0, 0, 0, '0, 0);
    for (int i = 0; i < 6; i++) drive(0, 1, 8'($urandom), 2'b01, 4'h0, 0, 0, '0, 0);
    drive(0, 1, 8'h55, 2'b00, 4'h0, 0, 0, '0, 0);
    drive(0, 0, 8'h00, 2'b10, 4'h0, 0, 0, '0, 0);
    drive(0, 1, 8'hAA, 2'b00, 4'h0, 0, 0, '0, 0);

    burst = 0;
    cur_de = 1'b0;
    for (int k = 0; k < 10000; k++) begin
      if (burst == 0) begin
        cur_de = !cur_de;
        burst = $urandom_range(1, 24);
      end
      burst--;
      if ($urandom_range(0, 1999) == 0)
        drive(1, 0, 8'h00, 2'b00, 4'h0, 0, 0, '0, 0);
      else
        drive(0, cur_de, 8'($urandom), 2'($urandom), 4'($urandom), 1'($urandom), 0, '0, 0);
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      rst = 1'b0; vid_de = 1'b0; ctrl = 2'b00; aux_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain got=%0d pending required=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tmds_encoder.md
Name: tmds_encoder

Overview:
- Single-channel DVI/HDMI TMDS 8b/10b encoder, transmit counterpart of the HDMI receive path (J3) in the Atlys design.
- Three instances (B, G, R) plus a serializer/OSERDES stage form the planned HDMI output port.
- Encodes pixel data with DC balancing via a running disparity counter during active video, and emits control tokens during blanking.

Parameters:
- RST_TOKEN, 10'b1101010100, 10-bit word driven after reset (control token for ctrl=00).

Ports:
- clk  input  1  pixel clock; all logic on rising edge
- rst  input  1  synchronous reset, active-high
- vid_data  input  8  pixel component byte
- vid_de  input  1  data enable: 1 = active video, 0 = blanking
- ctrl  input  2  {C1,C0} control bits, used when vid_de=0
- aux_data  input  4  TERC4 nibble (used only with TMDS_TERC4_EN)
- aux_valid  input  1  data-island period indicator (used only with TMDS_TERC4_EN)
- tmds_out  output  10  encoded symbol, bit 0 transmitted first

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Fixed latency of 2 clk cycles, input to tmds_out.
- No backpressure. One symbol per cycle, continuously.
- Stage 1 (registered):
  - n1 = popcount(vid_data).
  - XNOR mode if n1>4, or n1==4 and vid_data[0]==0; otherwise XOR mode.
  - q_m[0] = d[0]; q_m[i] = q_m[i-1] XOR/XNOR d[i] for i=1..7.
  - q_m[8] = 1 for XOR, 0 for XNOR.
  - Register q_m[8:0], vid_de, ctrl, aux_data and aux_valid.
- Stage 2 (registered):
  - Compute n1q and n0q over q_m[7:0].
  - cnt is a 5-bit signed running disparity, range -8..+8. No overflow is possible; the bench asserts this.
- Stage 2, active video (de=1), three cases:
  - Case A, cnt==0 or n1q==n0q:
    - out = {~q_m8, q_m8, q_m8 ? q_m[7:0] : ~q_m[7:0]}
    - cnt += q_m8 ? (n1q-n0q) : (n0q-n1q)
  - Case B, (cnt>0 and n1q>n0q) or (cnt<0 and n0q>n1q):
    - out = {1, q_m8, ~q_m[7:0]}
    - cnt += 2*q_m8 + (n0q-n1q)
  - Case C, otherwise:
    - out = {0, q_m8, q_m[7:0]}
    - cnt += (n1q-n0q) - 2*(~q_m8)
- Stage 2, blanking (de=0):
  - cnt <= 0.
  - Token by ctrl: 00→1101010100, 01→0010101011, 10→0101010100, 11→1010101011.
- Priority: de=1 overrides aux_valid and ctrl.
- Reset:
  - Both pipeline stages are cleared: stage-1 de=0, ctrl=00, aux_valid=0.
  - cnt=0; tmds_out=RST_TOKEN.
  - On the cycle after rst deasserts, tmds_out is still RST_TOKEN. The first input symbol appears 2 cycles after it is presented.
  - Reset mid-line discards any in-flight symbols; disparity restarts at 0.
- de transitions: the first active symbol after blanking is encoded with cnt=0. Back-to-back de toggles need no bubble.

Optional Feature:
- Macro: TMDS_TERC4_EN.
- Defined: when de=0 and aux_valid=1, stage 2 outputs the TERC4 code of aux_data and sets cnt <= 0.
  - 0:1010011100 1:1001100011 2:1011100100 3:1011100010
  - 4:0101110001 5:0100011110 6:0110001110 7:0100111100
  - 8:1011001100 9:0100111001 A:0110011100 B:1011000110
  - C:1010001110 D:1001110001 E:0101100011 F:1011000011
- Undefined: aux_data and aux_valid are ignored and their registers are removed; blanking always emits control tokens. The ports remain in both builds.

Decomposition:
- Package tmds_pkg holds:
  - the four control token constants
  - the TERC4 16-entry table constant
  - function popcount8 (returns 4-bit)
- No sub-module: the datapath is a two-stage pipeline in one module of roughly 150 lines.

Test Plan:
- Reset: rst=1 for 3 cycles, then vid_de=0, ctrl=00 → tmds_out=1101010100 throughout, including the 2 cycles after release.
- Control tokens: de=0, ctrl stepping 00,01,10,11 → after 2 cycles, 1101010100, 0010101011, 0101010100, 1010101011 in order.
- DC balance on constant data: de=1, vid_data=0x00 for 4 cycles from cnt=0 → 0100000000, 1111111111, 0100000000, 1111111111; cnt trace -8, 2, -6, 4.
- XNOR path: de=1, vid_data=0xFF from cnt=0 → 1000000000, cnt=-8.
- Reference model, random traffic: 10,000 random bytes with random de bursts, compared against a behavioural model →
  - outputs match exactly
  - |cnt| ≤ 8 always
  - decoding tmds_out recovers vid_data
  - cnt is 0 after each blanking
- TERC4 (macro defined): de=0, aux_valid=1, aux_data 0..F → table codes in order, 2-cycle latency. A de=1 cycle inserted mid-run takes priority and outputs the video code.
